// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: frame states and output mux codes.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit counter: clear, enable, synchronous reset, terminal count at DATA_WIDTH-1.
module uart_tx_bit_cnt #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 tc
);

    assign tc = (count == CNT_WIDTH'(DATA_WIDTH - 1));

    // Explicit wrap so non-power-of-two widths still return to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, data bits (LSB first), optional parity, stop.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Data_Valid,
    input  logic                 PAR_EN,
    output logic                 Load,
    output logic                 Ser_En,
    output logic [CNT_WIDTH-1:0] Bit_Idx,
    output logic [1:0]           Mux_Sel,
    output logic                 BUSY
);

    state_t state;
    logic   par_en_q;
    logic   accept;
    logic   cnt_en;
    logic   cnt_tc;

    assign accept = (state == IDLE) && Data_Valid;
    // Reset takes priority over a same-cycle request.
    assign Load   = accept && !RST;
    assign cnt_en = (state == DATA);

    uart_tx_bit_cnt #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_bit_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (accept),
        .en    (cnt_en),
        .count (Bit_Idx),
        .tc    (cnt_tc)
    );

    // Outputs are registered together with the state they decode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            par_en_q <= 1'b0;
            Ser_En   <= 1'b0;
            Mux_Sel  <= MUX_STOP;
            BUSY     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        state    <= START;
                        par_en_q <= PAR_EN;
                        Mux_Sel  <= MUX_START;
                        BUSY     <= 1'b1;
                    end
                    Ser_En <= 1'b0;
                end
                START: begin
                    state   <= DATA;
                    Ser_En  <= 1'b1;
                    Mux_Sel <= MUX_DATA;
                    BUSY    <= 1'b1;
                end
                DATA: begin
                    if (cnt_tc) begin
                        Ser_En <= 1'b0;
                        if (par_en_q) begin
                            state   <= PARITY;
                            Mux_Sel <= MUX_PAR;
                        end else begin
                            state   <= STOP;
                            Mux_Sel <= MUX_STOP;
                        end
                    end
                    BUSY <= 1'b1;
                end
                PARITY: begin
                    state   <= STOP;
                    Ser_En  <= 1'b0;
                    Mux_Sel <= MUX_STOP;
                    BUSY    <= 1'b1;
                end
                STOP: begin
                    state   <= IDLE;
                    Ser_En  <= 1'b0;
                    Mux_Sel <= MUX_STOP;
                    BUSY    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    Ser_En  <= 1'b0;
                    Mux_Sel <= MUX_STOP;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with DATA_WIDTH=8.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       Load;
    logic       Ser_En;
    logic [2:0] Bit_Idx;
    logic [1:0] Mux_Sel;
    logic       BUSY;

    int tests = 0;
    int fails = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .Load       (Load),
        .Ser_En     (Ser_En),
        .Bit_Idx    (Bit_Idx),
        .Mux_Sel    (Mux_Sel),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next();
        @(posedge CLK);
        #2;
    endtask

    task automatic check1(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic l, input logic s,
                       input logic [2:0] idx, input logic [1:0] m, input logic b);
        check1({tag, ".Load"},    {2'b0, Load},    {2'b0, l});
        check1({tag, ".Ser_En"},  {2'b0, Ser_En},  {2'b0, s});
        check1({tag, ".Bit_Idx"}, Bit_Idx,         idx);
        check1({tag, ".Mux_Sel"}, {1'b0, Mux_Sel}, {1'b0, m});
        check1({tag, ".BUSY"},    {2'b0, BUSY},    {2'b0, b});
    endtask

    // Expected outputs k cycles after a frame request seen in IDLE.
    task automatic expect_at(input int k, input bit par, input bit dv,
                             output logic l, output logic s, output logic [2:0] idx,
                             output logic [1:0] m, output logic b);
        int len;
        int p;
        len = par ? 12 : 11;
        p   = k % len;
        l = 1'b0; s = 1'b0; idx = 3'd0; m = 2'b01; b = 1'b0;
        if (p == 0) begin
            l = dv;
        end else if (p == 1) begin
            m = 2'b00; b = 1'b1;
        end else if (p <= 9) begin
            s = 1'b1; idx = 3'(p - 2); m = 2'b10; b = 1'b1;
        end else if (par && p == 10) begin
            m = 2'b11; b = 1'b1;
        end else begin
            m = 2'b01; b = 1'b1;
        end
    endtask

    // Runs ncycles starting from an IDLE cycle; optional PAR_EN drop or reset at given cycle.
    task automatic run(input string tag, input bit par, input int ncycles, input bit dv_hold,
                       input int drop_at, input int rst_at);
        logic l, s, b;
        logic [2:0] idx;
        logic [1:0] m;
        for (int k = 0; k < ncycles; k++) begin
            next();
            Data_Valid = (k == 0) || dv_hold;
            PAR_EN     = (k == 0) ? par : PAR_EN;
            if (k == drop_at) PAR_EN = 1'b0;
            if (k == rst_at) RST = 1'b1;
            #1;
            expect_at(k, par, Data_Valid, l, s, idx, m, b);
            chk($sformatf("%s.k%0d", tag, k), l, s, idx, m, b);
            if (k == rst_at) break;
        end
    endtask

    initial begin
        RST = 1'b1; Data_Valid = 1'b0; PAR_EN = 1'b0;
        next();
        next();
        #1 chk("reset", 1'b0, 1'b0, 3'd0, 2'b01, 1'b0);

        // Request during reset must not produce Load or start a frame.
        Data_Valid = 1'b1;
        #1 chk("rst_dv", 1'b0, 1'b0, 3'd0, 2'b01, 1'b0);
        next();
        RST = 1'b0; Data_Valid = 1'b0;
        #1 chk("after_rst_dv", 1'b0, 1'b0, 3'd0, 2'b01, 1'b0);

        for (int i = 0; i < 5; i++) begin
            next();
            #1 chk($sformatf("idle%0d", i), 1'b0, 1'b0, 3'd0, 2'b01, 1'b0);
        end

        run("par_frame",   1'b1, 13, 1'b0, -1, -1);
        run("nopar_frame", 1'b0, 12, 1'b0, -1, -1);
        run("dv_hold",     1'b1, 24, 1'b1, -1, -1);
        next();
        Data_Valid = 1'b0;
        #1 chk("dv_hold_end", 1'b0, 1'b0, 3'd0, 2'b01, 1'b0);

        run("par_drop", 1'b1, 13, 1'b0, 4, -1);
        PAR_EN = 1'b1;

        run("abort", 1'b1, 7, 1'b0, -1, 6);
        next();
        RST = 1'b0;
        #1 chk("abort_idle", 1'b0, 1'b0, 3'd0, 2'b01, 1'b0);
        run("after_abort", 1'b1, 13, 1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
